// File: rtl/fir_pkg.sv
// Shared types and helpers for the parallel-FIR tap loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: loader state enum, window-size function, slot-slice macro.

`ifndef FIR_SLOT
// Slot j of a packed vector made of w-bit slots; slot 0 sits in the LSBs.
`define FIR_SLOT(vec, j, w) vec[((j)+1)*(w)-1 -: (w)]
`endif

package fir_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } fir_state_t;

    // Samples a P-wide sliding window must hold to feed N taps on every lane.
    function automatic int nb_win(input int n, input int p);
        return n + p - 1;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Serial-load coefficient register bank: one coefficient per write, in tap order.
// Latency: a write is visible on o_coeffs the next cycle; o_done rises the cycle after the last write.
// Backpressure: none; writes beyond the last tap are ignored until the index is cleared.
//
// Ports: clk, i_reset (sync, active high), i_clear_idx (restart at tap 0, contents kept),
//        i_wr_en/i_coeff (write h[idx]), o_idx (next tap to write), o_done (full set loaded),
//        o_coeffs (slot k = h[k]).

module fir_coeff_bank #(
    parameter int NB_COEFFS = 8,
    parameter int N_COEFFS  = 8,
    localparam int IW       = $clog2(N_COEFFS + 1)
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          i_clear_idx,
    input  logic                          i_wr_en,
    input  logic [NB_COEFFS-1:0]          i_coeff,
    output logic [IW-1:0]                 o_idx,
    output logic                          o_done,
    output logic [NB_COEFFS*N_COEFFS-1:0] o_coeffs
);
    import fir_pkg::*;

    logic [IW-1:0]                 idx_q, idx_d;
    logic [NB_COEFFS*N_COEFFS-1:0] coeffs_q, coeffs_d;

    always_comb begin
        idx_d    = idx_q;
        coeffs_d = coeffs_q;
        // Clearing the index wins over a write in the same cycle.
        if (i_clear_idx) begin
            idx_d = '0;
        end else if (i_wr_en && (idx_q < IW'(N_COEFFS))) begin
            for (int k = 0; k < N_COEFFS; k++) begin
                if (idx_q == IW'(k)) begin
                    `FIR_SLOT(coeffs_d, k, NB_COEFFS) = i_coeff;
                end
            end
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            idx_q    <= '0;
            coeffs_q <= '0;
        end else begin
            idx_q    <= idx_d;
            coeffs_q <= coeffs_d;
        end
    end

    assign o_idx    = idx_q;
    assign o_done   = (idx_q == IW'(N_COEFFS));
    assign o_coeffs = coeffs_q;

endmodule

// File: rtl/fir_window_loader.sv
// Builds the packed sliding sample window and coefficient bank for a P-lane parallel FIR.
// Latency: accepted beat -> o_valid/o_window one cycle later; 1 beat/cycle with i_ready high.
// Backpressure: o_ready drops while coefficients load or while a window is held unconsumed.
//
// Ports: clk, i_reset (sync, active high); i_coeff_start/i_coeff_valid/i_coeff (serial tap load);
//        i_valid/o_ready/i_data (sample beats, lane 0 oldest); o_valid/i_ready/o_window
//        (slot j = x[n-j]); o_coeffs (slot k = h[k]); o_coeffs_ok (full tap set present).

module fir_window_loader
    import fir_pkg::*;
#(
    parameter int NB_IN     = 8,
    parameter int NB_COEFFS = 8,
    parameter int N_COEFFS  = 8,
    parameter int P         = 2,
    localparam int NB_WIN   = nb_win(N_COEFFS, P)
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          i_coeff_start,
    input  logic                          i_coeff_valid,
    input  logic [NB_COEFFS-1:0]          i_coeff,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [NB_IN*P-1:0]            i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [NB_IN*NB_WIN-1:0]       o_window,
    output logic [NB_COEFFS*N_COEFFS-1:0] o_coeffs,
    output logic                          o_coeffs_ok
);

    localparam int FW = $clog2(NB_WIN + 1);
    localparam int IW = $clog2(N_COEFFS + 1);

    fir_state_t                state_q, state_d;
    logic [FW-1:0]             fill_q, fill_d;
    logic [FW:0]               fill_sum;
    logic [NB_IN*NB_WIN-1:0]   window_q, window_d, shifted;
    logic                      valid_q, valid_d;
    logic                      accept, wr_en, last_wr;
    logic [IW-1:0]             coeff_idx;

    assign o_ready = (state_q != LOAD) && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;
    assign wr_en   = i_coeff_valid && (state_q == LOAD) && !i_coeff_start;
    assign last_wr = wr_en && (coeff_idx == IW'(N_COEFFS - 1));

    fir_coeff_bank #(
        .NB_COEFFS (NB_COEFFS),
        .N_COEFFS  (N_COEFFS)
    ) u_coeff_bank (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_clear_idx (i_coeff_start),
        .i_wr_en     (wr_en),
        .i_coeff     (i_coeff),
        .o_idx       (coeff_idx),
        .o_done      (o_coeffs_ok),
        .o_coeffs    (o_coeffs)
    );

    // Window shifted up by P slots: newest lane lands in slot 0, oldest P slots fall off.
    always_comb begin
        shifted = '0;
        for (int j = 0; j < P; j++) begin
            `FIR_SLOT(shifted, j, NB_IN) = `FIR_SLOT(i_data, P-1-j, NB_IN);
        end
        for (int j = P; j < NB_WIN; j++) begin
            `FIR_SLOT(shifted, j, NB_IN) = `FIR_SLOT(window_q, j-P, NB_IN);
        end
    end

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        window_d = window_q;
        valid_d  = valid_q;
        fill_sum = {1'b0, fill_q} + (FW+1)'(P);

        if (i_coeff_start) begin
            // Flush: any beat accepted this cycle is dropped with the window.
            state_d  = LOAD;
            fill_d   = '0;
            window_d = '0;
            valid_d  = 1'b0;
        end else begin
            if (last_wr) begin
                state_d = PRIME;
            end
            if (accept) begin
                window_d = shifted;
                fill_d   = (fill_sum >= (FW+1)'(NB_WIN)) ? FW'(NB_WIN) : fill_sum[FW-1:0];
                valid_d  = (fill_d >= FW'(NB_WIN));
                if ((state_q == PRIME) && (fill_d >= FW'(NB_WIN))) begin
                    state_d = RUN;
                end
            end else if (i_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q  <= LOAD;
            fill_q   <= '0;
            window_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            window_q <= window_d;
            valid_q  <= valid_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_window = window_q;

endmodule

// File: tb/tb_fir_window_loader.sv
module tb_fir_window_loader;

    localparam int NB_IN = 8;
    localparam int N     = 8;
    localparam int P     = 2;
    localparam int NBW   = N + P - 1;
    localparam int N1    = 4;
    localparam int NBW1  = N1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter DUT
    logic                  rst, cstart, cvalid, ivalid, iready;
    logic [7:0]            coeff;
    logic [NB_IN*P-1:0]    idata;
    logic                  oready, ovalid, ook;
    logic [NB_IN*NBW-1:0]  owin;
    logic [8*N-1:0]        ocoeffs;

    // P=1, N_COEFFS=4 DUT
    logic                  b_cstart, b_cvalid, b_ivalid, b_iready;
    logic [7:0]            b_coeff;
    logic [NB_IN-1:0]      b_idata;
    logic                  b_oready, b_ovalid, b_ook;
    logic [NB_IN*NBW1-1:0] b_owin;
    logic [8*N1-1:0]       b_ocoeffs;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: coefficients, sample history since last flush, consumer-side valid
    logic [7:0] exp_coeffs [N];
    logic [7:0] hist [$];
    bit         exp_valid;
    logic [7:0] b_exp_coeffs [N1];
    logic [7:0] b_hist [$];

    fir_window_loader #(.NB_IN(8), .NB_COEFFS(8), .N_COEFFS(N), .P(P)) dut (
        .clk(clk), .i_reset(rst), .i_coeff_start(cstart), .i_coeff_valid(cvalid),
        .i_coeff(coeff), .i_valid(ivalid), .o_ready(oready), .i_data(idata),
        .o_valid(ovalid), .i_ready(iready), .o_window(owin), .o_coeffs(ocoeffs),
        .o_coeffs_ok(ook)
    );

    fir_window_loader #(.NB_IN(8), .NB_COEFFS(8), .N_COEFFS(N1), .P(1)) dut_b (
        .clk(clk), .i_reset(rst), .i_coeff_start(b_cstart), .i_coeff_valid(b_cvalid),
        .i_coeff(b_coeff), .i_valid(b_ivalid), .o_ready(b_oready), .i_data(b_idata),
        .o_valid(b_ovalid), .i_ready(b_iready), .o_window(b_owin), .o_coeffs(b_ocoeffs),
        .o_coeffs_ok(b_ook)
    );

    // Expected window: the last NBW samples since flush, newest first, zero-padded.
    function automatic logic [NB_IN*NBW-1:0] win_a();
        logic [NB_IN*NBW-1:0] v = '0;
        for (int j = 0; j < NBW; j++)
            if (j < hist.size()) v[j*8 +: 8] = hist[hist.size()-1-j];
        return v;
    endfunction

    function automatic logic [NB_IN*NBW1-1:0] win_b();
        logic [NB_IN*NBW1-1:0] v = '0;
        for (int j = 0; j < NBW1; j++)
            if (j < b_hist.size()) v[j*8 +: 8] = b_hist[b_hist.size()-1-j];
        return v;
    endfunction

    function automatic logic [8*N-1:0] coeffs_a();
        logic [8*N-1:0] v;
        for (int k = 0; k < N; k++) v[k*8 +: 8] = exp_coeffs[k];
        return v;
    endfunction

    function automatic logic [8*N1-1:0] coeffs_b();
        logic [8*N1-1:0] v;
        for (int k = 0; k < N1; k++) v[k*8 +: 8] = b_exp_coeffs[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: serial load of N random coefficients into the default DUT.
    task automatic load_random_a();
        for (int k = 0; k < N; k++) begin
            cvalid = 1'b1;
            coeff  = 8'($urandom);
            exp_coeffs[k] = coeff;
            tick();
        end
        cvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ovalid); end
        n_tests++; if (ook !== 1'b0) begin n_fail++; $display("FAIL reset_coeffs_ok: got %b want 0", ook); end
        n_tests++; if (oready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", oready); end
        n_tests++; if (owin !== '0) begin n_fail++; $display("FAIL reset_window: got %h want 0", owin); end
        n_tests++; if (ocoeffs !== '0) begin n_fail++; $display("FAIL reset_coeffs: got %h want 0", ocoeffs); end
        n_tests++; if (b_ook !== 1'b0 || b_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_b: ok=%b valid=%b want 0 0", b_ook, b_ovalid); end
        rst = 1'b0;
        for (int k = 0; k < N; k++) exp_coeffs[k] = '0;
        for (int k = 0; k < N1; k++) b_exp_coeffs[k] = '0;
    endtask

    task automatic test_coeff_load();
        for (int k = 0; k < N; k++) begin
            cvalid = 1'b1;
            coeff  = 8'(k + 1);
            exp_coeffs[k] = coeff;
            tick();
            if (k < N - 1) begin
                n_tests++; if (ook !== 1'b0) begin n_fail++; $display("FAIL load_ok_early k=%0d: got %b want 0", k, ook); end
            end
        end
        cvalid = 1'b0;
        n_tests++; if (ook !== 1'b1) begin n_fail++; $display("FAIL load_ok: got %b want 1", ook); end
        n_tests++; if (ocoeffs !== coeffs_a()) begin n_fail++; $display("FAIL load_coeffs: got %h want %h", ocoeffs, coeffs_a()); end
        n_tests++; if (oready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", oready); end
        hist.delete();
        exp_valid = 1'b0;
    endtask

    task automatic test_stream();
        iready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            ivalid = 1'b1;
            idata  = {8'(2*b + 2), 8'(2*b + 1)};
            tick();
            hist.push_back(8'(2*b + 1));
            hist.push_back(8'(2*b + 2));
            n_tests++; if (ovalid !== (hist.size() >= NBW)) begin n_fail++; $display("FAIL stream_valid beat=%0d: got %b want %b", b, ovalid, hist.size() >= NBW); end
            n_tests++; if (owin !== win_a()) begin n_fail++; $display("FAIL stream_window beat=%0d: got %h want %h", b, owin, win_a()); end
        end
        ivalid = 1'b0;
        iready = 1'b0;
        exp_valid = 1'b1;
    endtask

    task automatic test_stall();
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++; if (oready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c=%0d: got %b want 0", c, oready); end
            n_tests++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c=%0d: got %b want 1", c, ovalid); end
            n_tests++; if (owin !== win_a()) begin n_fail++; $display("FAIL stall_window c=%0d: got %h want %h", c, owin, win_a()); end
        end
        iready = 1'b1;
        ivalid = 1'b1;
        idata  = {8'd12, 8'd11};
        tick();
        hist.push_back(8'd11);
        hist.push_back(8'd12);
        ivalid = 1'b0;
        n_tests++; if (owin[7:0] !== 8'd12 || owin[15:8] !== 8'd11) begin n_fail++; $display("FAIL release_slots: got %0d,%0d want 12,11", owin[7:0], owin[15:8]); end
        n_tests++; if (owin !== win_a()) begin n_fail++; $display("FAIL release_window: got %h want %h", owin, win_a()); end
        n_tests++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL release_valid: got %b want 1", ovalid); end
    endtask

    task automatic test_random_stream();
        bit exp_ready;
        for (int c = 0; c < 300; c++) begin
            ivalid = 1'($urandom_range(0, 1));
            iready = ($urandom_range(0, 3) != 0);
            idata  = 16'($urandom);
            #1;
            exp_ready = !exp_valid || iready;
            n_tests++; if (oready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, oready, exp_ready); end
            if (ivalid && exp_ready) begin
                hist.push_back(idata[7:0]);
                hist.push_back(idata[15:8]);
                exp_valid = (hist.size() >= NBW);
            end else if (iready) begin
                exp_valid = 1'b0;
            end
            tick();
            n_tests++; if (ovalid !== exp_valid) begin n_fail++; $display("FAIL rand_valid c=%0d: got %b want %b", c, ovalid, exp_valid); end
            n_tests++; if (owin !== win_a()) begin n_fail++; $display("FAIL rand_window c=%0d: got %h want %h", c, owin, win_a()); end
        end
        ivalid = 1'b0;
    endtask

    task automatic test_start();
        iready = 1'b1;
        ivalid = 1'b1;
        idata  = 16'($urandom);
        cstart = 1'b1;
        #1;
        n_tests++; if (oready !== 1'b1) begin n_fail++; $display("FAIL start_pre_ready: got %b want 1", oready); end
        tick();
        cstart = 1'b0;
        ivalid = 1'b0;
        hist.delete();
        exp_valid = 1'b0;
        n_tests++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL start_valid: got %b want 0", ovalid); end
        n_tests++; if (oready !== 1'b0) begin n_fail++; $display("FAIL start_ready: got %b want 0", oready); end
        n_tests++; if (owin !== '0) begin n_fail++; $display("FAIL start_window: got %h want 0", owin); end
        n_tests++; if (ocoeffs !== coeffs_a()) begin n_fail++; $display("FAIL start_coeffs_kept: got %h want %h", ocoeffs, coeffs_a()); end
        n_tests++; if (ook !== 1'b0) begin n_fail++; $display("FAIL start_ok: got %b want 0", ook); end
        // start together with a coefficient write: the write must be dropped
        cstart = 1'b1;
        cvalid = 1'b1;
        coeff  = ~exp_coeffs[0];
        tick();
        cstart = 1'b0;
        cvalid = 1'b0;
        n_tests++; if (ocoeffs !== coeffs_a()) begin n_fail++; $display("FAIL start_wins_write: got %h want %h", ocoeffs, coeffs_a()); end
        load_random_a();
        n_tests++; if (ocoeffs !== coeffs_a()) begin n_fail++; $display("FAIL reload_coeffs: got %h want %h", ocoeffs, coeffs_a()); end
        n_tests++; if (ook !== 1'b1) begin n_fail++; $display("FAIL reload_ok: got %b want 1", ook); end
    endtask

    task automatic test_run_writes();
        iready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            ivalid = 1'b1;
            idata  = 16'($urandom);
            hist.push_back(idata[7:0]);
            hist.push_back(idata[15:8]);
            tick();
        end
        ivalid = 1'b0;
        n_tests++; if (ovalid !== 1'b1 || owin !== win_a()) begin n_fail++; $display("FAIL run_fill: valid=%b win=%h want 1 %h", ovalid, owin, win_a()); end
        for (int c = 0; c < 3; c++) begin
            cvalid = 1'b1;
            coeff  = 8'($urandom);
            tick();
            n_tests++; if (ocoeffs !== coeffs_a()) begin n_fail++; $display("FAIL run_write_ignored c=%0d: got %h want %h", c, ocoeffs, coeffs_a()); end
            n_tests++; if (ook !== 1'b1) begin n_fail++; $display("FAIL run_write_ok c=%0d: got %b want 1", c, ook); end
        end
        cvalid = 1'b0;
    endtask

    task automatic test_reset_midload();
        cstart = 1'b1;
        tick();
        cstart = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cvalid = 1'b1;
            coeff  = 8'($urandom);
            tick();
        end
        cvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hist.delete();
        exp_valid = 1'b0;
        for (int k = 0; k < N; k++) exp_coeffs[k] = '0;
        n_tests++; if (ocoeffs !== '0) begin n_fail++; $display("FAIL midrst_coeffs: got %h want 0", ocoeffs); end
        n_tests++; if (ook !== 1'b0 || ovalid !== 1'b0 || oready !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: ok=%b valid=%b ready=%b want 0 0 0", ook, ovalid, oready); end
        n_tests++; if (owin !== '0) begin n_fail++; $display("FAIL midrst_window: got %h want 0", owin); end
        load_random_a();
        n_tests++; if (ocoeffs !== coeffs_a() || ook !== 1'b1) begin n_fail++; $display("FAIL midrst_reload: got %h ok=%b want %h ok=1", ocoeffs, ook, coeffs_a()); end
    endtask

    task automatic test_p1();
        b_iready = 1'b1;
        for (int k = 0; k < N1; k++) begin
            b_cvalid = 1'b1;
            b_coeff  = 8'($urandom);
            b_exp_coeffs[k] = b_coeff;
            tick();
        end
        b_cvalid = 1'b0;
        n_tests++; if (b_ook !== 1'b1 || b_ocoeffs !== coeffs_b()) begin n_fail++; $display("FAIL p1_coeffs: got %h ok=%b want %h ok=1", b_ocoeffs, b_ook, coeffs_b()); end
        for (int i = 0; i < 8; i++) begin
            b_ivalid = 1'b1;
            b_idata  = 8'($urandom);
            tick();
            b_hist.push_back(b_idata);
            n_tests++; if (b_ovalid !== (b_hist.size() >= NBW1)) begin n_fail++; $display("FAIL p1_valid i=%0d: got %b want %b", i, b_ovalid, b_hist.size() >= NBW1); end
            n_tests++; if (b_owin !== win_b()) begin n_fail++; $display("FAIL p1_window i=%0d: got %h want %h", i, b_owin, win_b()); end
        end
        b_ivalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cstart = 1'b0; cvalid = 1'b0; coeff = '0;
        ivalid = 1'b0; iready = 1'b1; idata = '0;
        b_cstart = 1'b0; b_cvalid = 1'b0; b_coeff = '0;
        b_ivalid = 1'b0; b_iready = 1'b0; b_idata = '0;
        exp_valid = 1'b0;
        test_reset();
        test_coeff_load();
        test_stream();
        test_stall();
        test_random_stream();
        test_start();
        test_run_writes();
        test_reset_midload();
        test_p1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
